// File: rtl/dmem_mp.sv
// PE-local data memory: streamed load port, delayed ALU write-back with 1-entry skid, NUM_RD registered read ports.
// Optional write-first forwarding on reads: define DMEM_BYPASS_EN (default build is pure read-first).
module dmem_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NUM_RD = 2,
  parameter int WB_DLY = 4,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_start,
  input  logic [ADDR_W-1:0]        ld_base,
  input  logic                     ld_valid,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     inst_v,
  input  logic [INST_W-1:0]        inst,
  input  logic                     rden,
  input  logic                     wb_valid,
  input  logic [DATA_W-1:0]        wb_data,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     rvalid,
  output logic                     wb_ovf
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] raddr_q [NUM_RD];
  logic [ADDR_W-1:0] wb_pipe_q [WB_DLY];
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d, ld_addr_s, wb_addr_s;
  logic              skid_full_q, skid_full_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              wb_ovf_d;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] rd_word_s [NUM_RD];
  logic              inst_unused_s;

  // Upper instruction bits beyond the address fields are not decoded here.
  assign inst_unused_s = ^inst;
  assign wb_addr_s     = wb_pipe_q[WB_DLY-1];

  // Single write port: load beats parked write-back, which beats fresh write-back.
  always_comb begin
    ld_addr_s   = ld_start ? ld_base : ld_ptr_q;
    ld_ptr_d    = ld_addr_s;
    skid_full_d = skid_full_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    wb_ovf_d    = wb_ovf;
    we_s        = 1'b0;
    waddr_s     = '0;
    wdata_s     = '0;
    if (ld_valid) begin
      ld_ptr_d = ld_addr_s + ADDR_W'(1);
      we_s     = 1'b1;
      waddr_s  = ld_addr_s;
      wdata_s  = ld_data;
      if (wb_valid && !skid_full_q) begin
        skid_full_d = 1'b1;
        skid_addr_d = wb_addr_s;
        skid_data_d = wb_data;
      end else if (wb_valid) begin
        wb_ovf_d = 1'b1;
      end else begin
        wb_ovf_d = wb_ovf;
      end
    end else if (skid_full_q) begin
      we_s    = 1'b1;
      waddr_s = skid_addr_q;
      wdata_s = skid_data_q;
      if (wb_valid) begin
        skid_addr_d = wb_addr_s;
        skid_data_d = wb_data;
      end else begin
        skid_full_d = 1'b0;
      end
    end else if (wb_valid) begin
      we_s    = 1'b1;
      waddr_s = wb_addr_s;
      wdata_s = wb_data;
    end else begin
      we_s = 1'b0;
    end
  end

  // Per-port read word; forwarding selects the committed write on an address hit.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
`ifdef DMEM_BYPASS_EN
      if (we_s && (waddr_s == raddr_q[k])) begin
        rd_word_s[k] = wdata_s;
      end else begin
        rd_word_s[k] = mem_q[raddr_q[k]];
      end
`else
      rd_word_s[k] = mem_q[raddr_q[k]];
`endif
    end
  end

  // Memory array is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  // Control state, address capture and registered read outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_ptr_q    <= '0;
      skid_full_q <= 1'b0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
      wb_ovf      <= 1'b0;
      rdata       <= '0;
      rvalid      <= 1'b0;
      for (int k = 0; k < NUM_RD; k++) raddr_q[k] <= '0;
      for (int i = 0; i < WB_DLY; i++) wb_pipe_q[i] <= '0;
    end else begin
      ld_ptr_q    <= ld_ptr_d;
      skid_full_q <= skid_full_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      wb_ovf      <= wb_ovf_d;
      rvalid      <= rden;
      wb_pipe_q[0] <= inst_v ? inst[8*NUM_RD +: ADDR_W] : '0;
      for (int i = 1; i < WB_DLY; i++) wb_pipe_q[i] <= wb_pipe_q[i-1];
      for (int k = 0; k < NUM_RD; k++) begin
        if (inst_v) raddr_q[k] <= inst[8*k +: ADDR_W];
        if (rden)   rdata[k*DATA_W +: DATA_W] <= rd_word_s[k];
      end
    end
  end

endmodule

// File: tb/tb_dmem_mp.sv
// Directed self-checking bench for dmem_mp with default parameters (2 read ports, WB_DLY=4).
module tb_dmem_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_base = 8'h00;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = 32'h0;
  logic        inst_v = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        rden = 1'b0;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_data = 32'h0;
  logic [63:0] rdata;
  logic        rvalid;
  logic        wb_ovf;

  int n_cmp = 0;
  int n_err = 0;

  dmem_mp dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_base(ld_base),
    .ld_valid(ld_valid), .ld_data(ld_data), .inst_v(inst_v), .inst(inst),
    .rden(rden), .wb_valid(wb_valid), .wb_data(wb_data),
    .rdata(rdata), .rvalid(rvalid), .wb_ovf(wb_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic start, input logic [7:0] base, input logic [31:0] d);
    ld_start = start; ld_base = base; ld_valid = 1'b1; ld_data = d;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
  endtask

  task automatic set_inst(input logic [31:0] w);
    inst_v = 1'b1; inst = w;
    tick();
    inst_v = 1'b0;
  endtask

  task automatic read_once();
    rden = 1'b1;
    tick();
    rden = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check_eq("rst_rdata", rdata, 64'h0);
    check_eq("rst_rvalid", {63'h0, rvalid}, 64'h0);
    check_eq("rst_wb_ovf", {63'h0, wb_ovf}, 64'h0);
    @(negedge clk); rst = 1'b1;
    tick();

    // streamed load at 0x10, read 0x10 / 0x13
    load(1'b1, 8'h10, 32'h1);
    load(1'b0, 8'h00, 32'h2);
    load(1'b0, 8'h00, 32'h3);
    load(1'b0, 8'h00, 32'h4);
    set_inst(32'h0000_1310);
    read_once();
    check_eq("t1_rdata", rdata, 64'h00000004_00000001);
    check_eq("t1_rvalid", {63'h0, rvalid}, 64'h1);
    tick();
    check_eq("t1_rvalid_drop", {63'h0, rvalid}, 64'h0);
    check_eq("t1_rdata_hold", rdata, 64'h00000004_00000001);

    // pointer wrap FE,FF,00
    load(1'b1, 8'hFE, 32'hA);
    load(1'b0, 8'h00, 32'hB);
    load(1'b0, 8'h00, 32'hC);
    set_inst(32'h0000_FFFE);
    read_once();
    check_eq("t2_fe_ff", rdata, 64'h0000000B_0000000A);
    set_inst(32'h0000_1100);
    read_once();
    check_eq("t2_00_11", rdata, 64'h00000002_0000000C);

    // delayed write-back to 0x20
    set_inst(32'h0020_0000);
    tick(); tick(); tick();
    wb_valid = 1'b1; wb_data = 32'h5A;
    tick();
    wb_valid = 1'b0;
    set_inst(32'h0000_1020);
    read_once();
    check_eq("t3_wb", rdata, 64'h00000001_0000005A);

    // collisions: park, overflow, drain-with-park
    set_inst(32'h0030_0000);
    set_inst(32'h0031_0000);
    set_inst(32'h0032_0000);
    tick();
    wb_valid = 1'b1; wb_data = 32'hAA;
    load(1'b1, 8'h40, 32'h111);
    check_eq("t4_no_ovf_yet", {63'h0, wb_ovf}, 64'h0);
    wb_data = 32'hBB;
    load(1'b0, 8'h00, 32'h222);
    check_eq("t4_ovf", {63'h0, wb_ovf}, 64'h1);
    wb_data = 32'hCC;
    tick();
    wb_valid = 1'b0;
    tick();
    set_inst(32'h0000_3230);
    read_once();
    check_eq("t4_parked", rdata, 64'h000000CC_000000AA);
    set_inst(32'h0000_4140);
    read_once();
    check_eq("t4_loads", rdata, 64'h00000222_00000111);

    // read/write same address
    load(1'b1, 8'h50, 32'h777);
    set_inst(32'h0000_1050);
    rden = 1'b1;
    load(1'b1, 8'h50, 32'h888);
    rden = 1'b0;
`ifdef DMEM_BYPASS_EN
    check_eq("t5_rw_same", rdata, 64'h00000001_00000888);
`else
    check_eq("t5_rw_same", rdata, 64'h00000001_00000777);
`endif
    read_once();
    check_eq("t5_after", rdata, 64'h00000001_00000888);
    check_eq("t5_ovf_sticky", {63'h0, wb_ovf}, 64'h1);

    // async reset in the middle of a load stream
    rden = 1'b1;
    load(1'b1, 8'h60, 32'h999);
    ld_valid = 1'b1; ld_data = 32'h99A;
    tick();
    #3 rst = 1'b0;
    #1;
    check_eq("t6_rdata", rdata, 64'h0);
    check_eq("t6_rvalid", {63'h0, rvalid}, 64'h0);
    check_eq("t6_wb_ovf", {63'h0, wb_ovf}, 64'h0);
    ld_valid = 1'b0; rden = 1'b0;
    @(negedge clk); rst = 1'b1;
    tick();
    load(1'b0, 8'h77, 32'hABC);
    read_once();
    check_eq("t6_ptr0", rdata, 64'h00000ABC_00000ABC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
